// File: rtl/ic1337_bist_pkg.sv
// Shared encodings for the ic1337 BIST controller: FSM states and the
// bit layout of one vector table entry.
package ic1337_bist_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int STIM_LSB = 0;
  localparam int EXP_LSB  = 3;
  localparam int MASK_LSB = 6;
  localparam int ENTRY_W  = 9;

endpackage

// File: rtl/ic1337_vec_mem.sv
// Vector table: DEPTH x ENTRY_W register file, one synchronous write port
// and one combinational read port. Contents are deliberately not reset.
module ic1337_vec_mem
  import ic1337_bist_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic               clk,
  input  logic               we,
  input  logic [AW-1:0]      waddr,
  input  logic [ENTRY_W-1:0] wdata,
  input  logic [AW-1:0]      raddr,
  output logic [ENTRY_W-1:0] rdata
);

  logic [ENTRY_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/ic1337_bist.sv
// Stimulus/self-check controller for the ic1337 circuit: drives table vectors,
// samples Q0/Q1/Z after a settle delay and reports masked mismatches.
module ic1337_bist
  import ic1337_bist_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int AW     = 3,
  parameter int SETTLE = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [8:0]    wr_data,
  input  logic [AW-1:0] num_vec,
  input  logic          start,
  output logic          drv_I0,
  output logic          drv_I1,
  output logic          drv_I2,
  input  logic          dut_Q0,
  input  logic          dut_Q1,
  input  logic          dut_Z,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [AW:0]   err_count,
  output logic [AW-1:0] first_err_idx
);

  state_t             state_reg, state_next;
  logic [AW-1:0]      idx_reg, last_reg, first_reg;
  logic [AW:0]        err_reg;
  logic [2:0]         cnt_reg, drv_reg, exp_reg, mask_reg;
  logic               wr_ok, start_ok, sample, final_sample, mismatch;
  logic [AW-1:0]      rd_addr;
  logic [ENTRY_W-1:0] rd_data, first_entry;

  assign wr_ok = wr_en && (state_reg != RUN);

  // While running, the read port looks one vector ahead so the next stimulus
  // is ready on the sample edge; otherwise it presents entry 0 for a start.
  assign rd_addr = (state_reg == RUN) ? idx_reg + AW'(1) : '0;

  // A write to entry 0 on the start edge must be seen by the run.
  assign first_entry = (wr_ok && (wr_addr == '0)) ? wr_data : rd_data;

  ic1337_vec_mem #(.DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk   (clk),
    .we    (wr_ok),
    .waddr (wr_addr),
    .wdata (wr_data),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  assign mismatch = |(({dut_Q0, dut_Q1, dut_Z} ^ exp_reg) & mask_reg);

  always_comb begin
    state_next   = state_reg;
    start_ok     = 1'b0;
    sample       = 1'b0;
    final_sample = 1'b0;
    case (state_reg)
      IDLE, DONE: begin
        if (start) begin
          start_ok   = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (cnt_reg == 3'(SETTLE)) begin
          sample = 1'b1;
          if (idx_reg == last_reg) begin
            final_sample = 1'b1;
            state_next   = DONE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      idx_reg   <= '0;
      last_reg  <= '0;
      cnt_reg   <= '0;
      drv_reg   <= '0;
      exp_reg   <= '0;
      mask_reg  <= '0;
      err_reg   <= '0;
      first_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (start_ok) begin
        err_reg   <= '0;
        first_reg <= '0;
        idx_reg   <= '0;
        last_reg  <= num_vec;
        cnt_reg   <= '0;
        drv_reg   <= first_entry[STIM_LSB +: 3];
        exp_reg   <= first_entry[EXP_LSB +: 3];
        mask_reg  <= first_entry[MASK_LSB +: 3];
      end else if (sample) begin
        if (mismatch) begin
          err_reg <= err_reg + (AW+1)'(1);
          if (err_reg == '0) begin
            first_reg <= idx_reg;
          end
        end
        if (!final_sample) begin
          idx_reg  <= idx_reg + AW'(1);
          cnt_reg  <= '0;
          drv_reg  <= rd_data[STIM_LSB +: 3];
          exp_reg  <= rd_data[EXP_LSB +: 3];
          mask_reg <= rd_data[MASK_LSB +: 3];
        end
      end else if (state_reg == RUN) begin
        cnt_reg <= cnt_reg + 3'd1;
      end
    end
  end

  assign drv_I0        = drv_reg[0];
  assign drv_I1        = drv_reg[1];
  assign drv_I2        = drv_reg[2];
  assign busy          = (state_reg == RUN);
  assign done          = (state_reg == DONE);
  assign pass          = (state_reg == DONE) && (err_reg == '0);
  assign err_count     = err_reg;
  assign first_err_idx = first_reg;

endmodule

// File: tb/tb_ic1337_bist.sv
// Self-checking bench for ic1337_bist: a loopback ic1337 stand-in with
// per-stimulus defect injection, and a table-level reference of run outcomes.
module tb_ic1337_bist;

  logic       clk = 1'b0;
  logic       rst_n, wr_en, start, start0;
  logic [2:0] wr_addr, num_vec;
  logic [8:0] wr_data;

  logic       drv_i0, drv_i1, drv_i2, busy, done, pass;
  logic [3:0] err_count;
  logic [2:0] first_err_idx;
  logic       q0, q1, z;

  logic       d0_i0, d0_i1, d0_i2, busy0, done0, pass0;
  logic [3:0] err0;
  logic [2:0] first0;
  logic       tie_lo = 1'b0;

  logic [8:0] tbl    [8];
  logic [2:0] defect [8];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ic1337_bist #(.DEPTH(8), .AW(3), .SETTLE(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .num_vec(num_vec), .start(start), .drv_I0(drv_i0), .drv_I1(drv_i1), .drv_I2(drv_i2),
    .dut_Q0(q0), .dut_Q1(q1), .dut_Z(z), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .first_err_idx(first_err_idx)
  );

  ic1337_bist #(.DEPTH(8), .AW(3), .SETTLE(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .num_vec(num_vec), .start(start0), .drv_I0(d0_i0), .drv_I1(d0_i1), .drv_I2(d0_i2),
    .dut_Q0(tie_lo), .dut_Q1(tie_lo), .dut_Z(tie_lo), .busy(busy0), .done(done0),
    .pass(pass0), .err_count(err0), .first_err_idx(first0)
  );

  // Loopback circuit: Q0<=I0, Q1<=I1, Z<=I2, corrupted by the defect of the stimulus code.
  always @(posedge clk) begin
    {q0, q1, z} <= {drv_i0, drv_i1, drv_i2} ^ defect[{drv_i2, drv_i1, drv_i0}];
  end

  function automatic logic [2:0] ideal(input logic [2:0] s);
    return {s[0], s[1], s[2]};
  endfunction

  // Outcome of running vectors 0..num straight from the table contents.
  function automatic void ref_run(input int num, output int e, output int f);
    logic [8:0] en;
    logic [2:0] obs;
    e = 0;
    f = 0;
    for (int k = 0; k <= num; k++) begin
      en  = tbl[k];
      obs = ideal(en[2:0]) ^ defect[en[2:0]];
      if (((obs ^ en[5:3]) & en[8:6]) != 3'b000) begin
        if (e == 0) f = k;
        e++;
      end
    end
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int addr, input logic [8:0] data);
    wr_en   = 1'b1;
    wr_addr = 3'(addr);
    wr_data = data;
    tick();
    wr_en   = 1'b0;
    tbl[addr] = data;
  endtask

  task automatic wait_done(input string tag, input int expect_cyc);
    int cyc = 0;
    while (done !== 1'b1 && cyc < 100) begin
      tick();
      cyc++;
    end
    check({tag, "_cycles"}, cyc, expect_cyc);
  endtask

  task automatic run_check(input string tag, input int num);
    int e, f;
    ref_run(num, e, f);
    num_vec = 3'(num);
    start   = 1'b1;
    tick();
    start   = 1'b0;
    check({tag, "_accept"}, {busy, done, err_count}, {2'b10, 4'd0});
    wait_done(tag, (num + 1) * 2);
    check({tag, "_err"}, err_count, e);
    check({tag, "_first"}, first_err_idx, f);
    check({tag, "_pass"}, {busy, pass}, {1'b0, e == 0});
    check({tag, "_drv"}, {drv_i2, drv_i1, drv_i0}, tbl[num][2:0]);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [2:0] r, s, e, m;
    int ee, ff;
    rst_n = 1'b0; wr_en = 1'b0; start = 1'b0; start0 = 1'b0;
    wr_addr = '0; wr_data = '0; num_vec = '0;
    for (int c = 0; c < 8; c++) defect[c] = 3'b000;
    repeat (3) tick();
    check("reset_flags", {busy, done, pass, drv_i2, drv_i1, drv_i0}, 6'd0);
    check("reset_err", {err_count, first_err_idx}, 7'd0);
    rst_n = 1'b1;
    tick();

    // Single vector: stim 001 with the circuit flipping Q0 back to 0.
    defect[1] = 3'b100;
    wr(0, {3'b111, 3'b000, 3'b001});
    run_check("single", 0);
    defect[1] = 3'b000;

    // Full table, Z flipped on vectors 3 and 6.
    r = 3'($urandom);
    for (int k = 0; k < 8; k++) begin
      s = 3'(k) ^ r;
      wr(k, {3'b111, ideal(s), s});
    end
    defect[tbl[3][2:0]] = 3'b001;
    defect[tbl[6][2:0]] = 3'b001;
    run_check("full", 7);

    // Reset two edges after the start edge aborts the run.
    num_vec = 3'd7;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    check("midrst_flags", {busy, done, drv_i2, drv_i1, drv_i0}, 5'd0);
    check("midrst_err", err_count, 4'd0);
    rst_n = 1'b1;
    tick();
    run_check("rerun", 7);

    // Masking: vector 2 differs only on Q1, which its mask ignores.
    for (int c = 0; c < 8; c++) defect[c] = 3'b000;
    defect[tbl[2][2:0]] = 3'b010;
    wr(2, {3'b101, tbl[2][5:0]});
    run_check("mask", 7);

    // Randomized tables, defects, masks and run lengths.
    for (int rnd = 0; rnd < 4; rnd++) begin
      for (int c = 0; c < 8; c++)
        defect[c] = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
      for (int k = 0; k < 8; k++) begin
        s = 3'($urandom);
        e = ideal(s) ^ (($urandom_range(0, 5) == 0) ? 3'($urandom) : 3'b000);
        m = 3'($urandom);
        wr(k, {m, e, s});
      end
      run_check("rand", $urandom_range(0, 7));
    end

    // Guards: start and a write to entry 0 during RUN are ignored.
    for (int c = 0; c < 8; c++) defect[c] = 3'b000;
    wr(0, {3'b111, 3'b111, 3'b000});
    ref_run(3, ee, ff);
    num_vec = 3'd3;
    start = 1'b1;
    tick();
    wr_en = 1'b1; wr_addr = 3'd0; wr_data = {3'b111, 3'b000, 3'b000};
    tick();
    tick();
    start = 1'b0; wr_en = 1'b0;
    wait_done("guard", 6);
    check("guard_err", err_count, ee);
    check("guard_first", first_err_idx, ff);
    run_check("readback", 0);

    // Write to entry 0 and start on the same edge: the run uses the new entry.
    wr_en = 1'b1; wr_addr = 3'd0; wr_data = {3'b111, ideal(3'b010), 3'b010};
    num_vec = 3'd0; start = 1'b1;
    tbl[0] = wr_data;
    tick();
    wr_en = 1'b0; start = 1'b0;
    ref_run(0, ee, ff);
    wait_done("wrstart", 2);
    check("wrstart_err", err_count, ee);

    // SETTLE=0 instance: one vector per edge, done three edges after start.
    wr(0, {3'b000, 3'b000, 3'b011});
    wr(1, {3'b000, 3'b000, 3'b101});
    wr(2, {3'b000, 3'b000, 3'b110});
    num_vec = 3'd2;
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    check("s0_drv0", {busy0, d0_i2, d0_i1, d0_i0}, {1'b1, 3'b011});
    tick();
    check("s0_drv1", {d0_i2, d0_i1, d0_i0}, 3'b101);
    tick();
    check("s0_drv2", {done0, d0_i2, d0_i1, d0_i0}, {1'b0, 3'b110});
    tick();
    check("s0_done", {busy0, done0, pass0, err0}, {3'b011, 4'd0});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
